fft_frame_tx: RTL
=================

# fft_frame_tx

Byte-serial frame transmitter that returns buffered FFT output bytes to the external host over the 8-bit IO bus, the outbound counterpart of the core's sample-input path. Internal logic writes result bytes into a small buffer. On `start`, the block emits one framed burst: header, length, payload, then an XOR checksum. Each byte transfers under a valid/ack handshake with the host. The block sits between the FFT datapath and the `uio_*` pins in the top-level wrapper.

## Interface
- `DEPTH`, 16: payload buffer entries (8-bit each), power of two, 2..64.
- `HDR`, 8'hA5: frame header byte.

- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `ena`  in  1: design enable; when low, all state holds.
- `wr_en`  in  1: write `wr_data` into the buffer.
- `wr_data`  in  8: payload byte.
- `start`  in  1: request transmission of the buffered frame.
- `tx_ack`  in  1: host accepts the current byte.
- `tx_data`  out  8: byte on the bus.
- `tx_valid`  out  1: `tx_data` is valid.
- `busy`  out  1: frame in progress (any state except IDLE).
- `done`  out  1: one-cycle pulse after the checksum byte is accepted.
- `err`  out  1: sticky flag for a dropped write.
- `count`  out  $clog2(DEPTH)+1: number of bytes currently buffered.

## Operation
- States: IDLE, HDR, LEN, PAY, CHK, DONE.
- **Reset:** state=IDLE, `tx_data`=0, `tx_valid`=0, `busy`=0, `done`=0, `err`=0, `count`=0, read pointer=0. Buffer contents are don't-care.
- **`ena` low:** no state, pointer, count or flag changes. Outputs hold, and `tx_valid`/`tx_data` stay stable.
- **Transfer:** a byte transfers on any rising edge where `tx_valid`=1 and `tx_ack`=1. `tx_data` must not change while `tx_valid`=1 and no transfer has occurred. `tx_ack` while `tx_valid`=0 is ignored.
- **IDLE:**
  - `wr_en` with `count`<DEPTH: store the byte at index `count`, then `count`+1.
  - `wr_en` with `count`=DEPTH: drop the byte and set `err`.
  - `start`: go to HDR, clear `err`, latch `len`=`count`, clear the checksum accumulator.
  - `start` and `wr_en` in the same cycle: the write is stored first, and `len` includes it (`len`=`count`+1). If the buffer is full, the byte is dropped and `err` stays set.
- **HDR:** `tx_data`=HDR. On transfer, go to LEN.
- **LEN:** `tx_data`=`len`. On transfer, go to PAY if `len`>0, else CHK.
- **PAY:** `tx_data`=buffer[rd_ptr]. On transfer, increment `rd_ptr`; after the byte at `rd_ptr`=`len`-1, go to CHK.
- **CHK:** `tx_data`=`len` XOR all payload bytes. The header is excluded. On transfer, go to DONE.
- **DONE:** one cycle with `done`=1 and `tx_valid`=0. Clear `count` and `rd_ptr` to 0, then go to IDLE.
- **Writes while not IDLE:** dropped, and `err` is set.
- **`start` while not IDLE:** ignored.
- **Width rules:** `len` occupies the full 8-bit byte, zero-extended from `count`. The checksum is an 8-bit XOR. `rd_ptr` never wraps within a frame.
- **Reset mid-frame:** immediate return to the reset values. The host sees `tx_valid` drop asynchronously; the partial frame is abandoned.

## Timing
- `start` sampled at edge N: `tx_valid`=1 with HDR from after edge N (registered outputs).
- All outputs are registered.
- With `tx_ack` held high, one byte transfers per cycle. A frame of `len` bytes takes `len`+3 transfer edges, and `done` is high in the cycle after the CHK transfer.
- Back-to-back frames: a new `start` is accepted once the state has returned to IDLE. The minimum is 1 cycle after `done`.
- `count` reflects a write on the cycle after the `wr_en` edge.

## Test plan
- **Reset values:** assert `rst_n` low mid-clock -> all outputs 0 immediately, without waiting for a clock edge.
- **Basic frame, `tx_ack` tied 1:** write 0x01, 0x02, 0x03, then pulse `start` -> bytes A5, 03, 01, 02, 03, 03 on consecutive cycles. Checksum 03 = 03^01^02^03. `done` pulses one cycle later, then `count`=0.
- **Empty frame:** `start` with `count`=0 -> bytes A5, 00, 00, then `done`.
- **Stalling host:** 2-byte frame 0xFF, 0x0F with `tx_ack` toggling 0/1 every cycle -> `tx_data` is stable during every stall. The sequence is A5, 02, FF, 0F, F2; no byte is duplicated or skipped.
- **Overflow:** write 17 bytes with DEPTH=16 -> `err`=1 and `count`=16. A following `start` clears `err` and sends `len`=0x10.
- **`ena` and reset during a frame:**
  - Drop `ena` during PAY with `tx_ack`=1 -> no transfers occur while `ena` is low, and the frame resumes at the same byte.
  - Assert `rst_n` mid-frame -> the FSM returns to IDLE with `count`=0.

Source files
------------

// File: rtl/fft_frame_tx.sv
// Byte-serial frame transmitter: buffers payload bytes, then sends header,
// length, payload and an XOR checksum to the host under a valid/ack handshake.
module fft_frame_tx #(
    parameter int unsigned DEPTH = 16,
    parameter logic [7:0]  HDR   = 8'hA5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     start,
    input  logic                     tx_ack,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LEN,
        S_PAY,
        S_CHK,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [7:0]     tx_data_q, tx_data_d;
    logic           tx_valid_q, tx_valid_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic [CW-1:0]  count_q, count_d;
    logic [CW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [7:0]     len_q, len_d;
    logic [7:0]     chk_q, chk_d;
    logic [7:0]     mem_q [DEPTH];

    logic           mem_we_c;
    logic           full_c;
    logic           xfer_c;
    logic [CW-1:0]  count_inc_c;
    logic [CW-1:0]  rd_inc_c;
    logic [7:0]     chk_pay_c;

    assign full_c      = (count_q == CW'(DEPTH));
    assign xfer_c      = tx_valid_q && tx_ack;
    assign count_inc_c = count_q + CW'(1);
    assign rd_inc_c    = rd_ptr_q + CW'(1);
    assign chk_pay_c   = chk_q ^ tx_data_q;

    // Next-state and registered-output logic; every register holds while ena is low.
    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        len_d      = len_q;
        chk_d      = chk_q;
        mem_we_c   = 1'b0;

        if (ena) begin
            done_d = 1'b0;
            if (wr_en && (state_q != S_IDLE)) begin
                err_d = 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (wr_en) begin
                        if (!full_c) begin
                            mem_we_c = 1'b1;
                            count_d  = count_inc_c;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    if (start) begin
                        // A same-cycle write lands first and is counted in len.
                        state_d    = S_HDR;
                        err_d      = wr_en && full_c;
                        len_d      = (wr_en && !full_c) ? 8'(count_inc_c) : 8'(count_q);
                        chk_d      = 8'h00;
                        tx_valid_d = 1'b1;
                        tx_data_d  = HDR;
                        busy_d     = 1'b1;
                    end
                end
                S_HDR: begin
                    if (xfer_c) begin
                        state_d   = S_LEN;
                        tx_data_d = len_q;
                        chk_d     = len_q;
                    end
                end
                S_LEN: begin
                    if (xfer_c) begin
                        if (len_q != 8'h00) begin
                            state_d   = S_PAY;
                            tx_data_d = mem_q[rd_ptr_q[PW-1:0]];
                        end else begin
                            state_d   = S_CHK;
                            tx_data_d = chk_q;
                        end
                    end
                end
                S_PAY: begin
                    if (xfer_c) begin
                        chk_d    = chk_pay_c;
                        rd_ptr_d = rd_inc_c;
                        if (8'(rd_ptr_q) == (len_q - 8'd1)) begin
                            state_d   = S_CHK;
                            tx_data_d = chk_pay_c;
                        end else begin
                            tx_data_d = mem_q[rd_inc_c[PW-1:0]];
                        end
                    end
                end
                S_CHK: begin
                    if (xfer_c) begin
                        state_d    = S_DONE;
                        tx_valid_d = 1'b0;
                        done_d     = 1'b1;
                    end
                end
                S_DONE: begin
                    state_d  = S_IDLE;
                    busy_d   = 1'b0;
                    count_d  = '0;
                    rd_ptr_d = '0;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            len_q      <= 8'h00;
            chk_q      <= 8'h00;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            len_q      <= len_d;
            chk_q      <= chk_d;
        end
    end

    // Payload buffer; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[count_q[PW-1:0]] <= wr_data;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign count    = count_q;

endmodule
